// File: rtl/bp_me_axil_master_pkg.sv
// Shared types for the BedRock-to-AXI4-Lite master bridge: BedRock header
// layout, AXI response/protection encodings, the bridge FSM states and the
// size-to-strobe helper reused by future AXI bridges.
package bp_me_axil_master_pkg;

    localparam int paddr_width_gp       = 40;
    localparam int mem_payload_width_gp = 16;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    // Header layout, most significant field first
    typedef struct packed {
        logic [mem_payload_width_gp-1:0] payload;
        bp_bedrock_msg_size_e            size;
        logic [paddr_width_gp-1:0]       addr;
        logic [3:0]                      subop;
        bp_bedrock_mem_type_e            msg_type;
    } bp_bedrock_mem_header_s;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_type_e;

    typedef enum logic [2:0] {
        e_axi_prot_default     = 3'b000,
        e_axi_prot_privileged  = 3'b001,
        e_axi_prot_nonsecure   = 3'b010,
        e_axi_prot_instruction = 3'b100
    } axi_prot_type_e;

    typedef enum logic [2:0] {
        e_ready  = 3'd0,
        e_write  = 3'd1,
        e_wait_b = 3'd2,
        e_read   = 3'd3,
        e_wait_r = 3'd4,
        e_resp   = 3'd5
    } bp_me_axil_state_e;

    // Physical address width supplied by a processor configuration
    function automatic int bp_paddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return paddr_width_gp;
            default:          return paddr_width_gp;
        endcase
    endfunction

    // Byte strobe for a 64-bit lane set; narrower buses keep the low bits.
    // The offset is rounded down to the natural alignment of the size.
    function automatic logic [7:0] size_to_strb(bp_bedrock_msg_size_e size, logic [2:0] offset);
        case (size)
            e_bedrock_msg_size_1: return 8'h01 << offset;
            e_bedrock_msg_size_2: return 8'h03 << {offset[2:1], 1'b0};
            e_bedrock_msg_size_4: return 8'h0F << {offset[2], 2'b00};
            default:              return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/bp_me_axil_strb_gen.sv
// Combinational write-lane generator: maps BedRock size and byte offset to an
// AXI write strobe and replicates the LSB-aligned payload across the bus so
// the enabled lanes always carry the right bytes.
module bp_me_axil_strb_gen
    import bp_me_axil_master_pkg::*;
#(
    parameter int data_width_p = 32,
    localparam int strb_width_lp = data_width_p / 8,
    localparam int lg_bytes_lp   = $clog2(strb_width_lp)
)(
    input  bp_bedrock_msg_size_e       size_i,
    input  logic [lg_bytes_lp-1:0]     offset_i,
    input  logic [data_width_p-1:0]    data_i,
    output logic [strb_width_lp-1:0]   wstrb_o,
    output logic [data_width_p-1:0]    wdata_o
);

    assign wstrb_o = strb_width_lp'(size_to_strb(size_i, 3'(offset_i)));

    for (genvar gi = 0; gi < strb_width_lp; gi++) begin : g_lane
        logic [7:0] lane_byte;

        // Each lane takes the payload byte at its position modulo the access size
        always_comb begin
            case (size_i)
                e_bedrock_msg_size_1: lane_byte = data_i[7:0];
                e_bedrock_msg_size_2: lane_byte = data_i[8*(gi%2)+:8];
                e_bedrock_msg_size_4: lane_byte = data_i[8*(gi%4)+:8];
                default:              lane_byte = data_i[8*gi+:8];
            endcase
        end

        assign wdata_o[8*gi+:8] = lane_byte;
    end

endmodule

// File: rtl/bp_me_axil_master.sv
// BedRock I/O command to AXI4-Lite master bridge. One transaction in flight;
// all AXI valids/readies and BedRock handshake outputs come from registers.
module bp_me_axil_master
    import bp_me_axil_master_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int axil_data_width_p   = 32,
    parameter int axil_addr_width_p   = 32,
    localparam int mem_header_width_lp = $bits(bp_bedrock_mem_header_s),
    localparam int axil_strb_width_lp  = axil_data_width_p / 8,
    localparam int lg_bytes_lp         = $clog2(axil_strb_width_lp)
)(
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [mem_header_width_lp-1:0] io_cmd_header_i,
    input  logic [axil_data_width_p-1:0]   io_cmd_data_i,
    input  logic                           io_cmd_v_i,
    output logic                           io_cmd_ready_and_o,
    input  logic                           io_cmd_last_i,

    output logic [mem_header_width_lp-1:0] io_resp_header_o,
    output logic [axil_data_width_p-1:0]   io_resp_data_o,
    output logic                           io_resp_v_o,
    input  logic                           io_resp_ready_and_i,
    output logic                           io_resp_last_o,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,

    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_strb_width_lp-1:0]  m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,

    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,

    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic [2:0]                     m_axil_arprot_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,

    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o,

    output logic                           error_o
);

    if (axil_data_width_p != 32 && axil_data_width_p != 64) begin : g_bad_data_width
        $error("bp_me_axil_master: axil_data_width_p must be 32 or 64");
    end
    if (axil_addr_width_p > bp_paddr_width(bp_params_p)) begin : g_bad_addr_width
        $error("bp_me_axil_master: axil_addr_width_p exceeds the physical address width");
    end

    bp_bedrock_mem_header_s        cmd_header_li;
    bp_bedrock_mem_header_s        header_reg;
    logic [axil_data_width_p-1:0]  data_reg;
    bp_me_axil_state_e             state_reg;

    logic cmd_ready_reg, aw_pend_reg, w_pend_reg, ar_reg;
    logic bready_reg, rready_reg, resp_v_reg, error_reg;
    logic [axil_data_width_p-1:0]  resp_data_reg;

    logic cmd_fire, cmd_is_write, cmd_is_read, cmd_size_ok, cmd_supported;
    logic [lg_bytes_lp-1:0]        offset;
    logic [axil_addr_width_p-1:0]  axil_addr;
    logic [axil_data_width_p-1:0]  rdata_shifted, rdata_masked;

    assign cmd_header_li = io_cmd_header_i;
    assign cmd_fire      = cmd_ready_reg & io_cmd_v_i;
    assign cmd_is_write  = (cmd_header_li.msg_type == e_bedrock_mem_wr)
                         | (cmd_header_li.msg_type == e_bedrock_mem_uc_wr);
    assign cmd_is_read   = (cmd_header_li.msg_type == e_bedrock_mem_rd)
                         | (cmd_header_li.msg_type == e_bedrock_mem_uc_rd);
    // Sizes wider than the bus cannot be carried by a single AXI4-Lite beat
    assign cmd_size_ok   = (int'(cmd_header_li.size) <= lg_bytes_lp);
    assign cmd_supported = (cmd_is_write | cmd_is_read) & cmd_size_ok & io_cmd_last_i;

    // Command header and payload capture on acceptance (enabled register)
    always_ff @(posedge clk_i) begin
        if (cmd_fire) begin
            header_reg <= cmd_header_li;
            data_reg   <= io_cmd_data_i;
        end
    end

    assign offset    = header_reg.addr[lg_bytes_lp-1:0];
    assign axil_addr = {header_reg.addr[axil_addr_width_p-1:lg_bytes_lp], {lg_bytes_lp{1'b0}}};

    bp_me_axil_strb_gen #(
        .data_width_p (axil_data_width_p)
    ) strb_gen (
        .size_i   (header_reg.size),
        .offset_i (offset),
        .data_i   (data_reg),
        .wstrb_o  (m_axil_wstrb_o),
        .wdata_o  (m_axil_wdata_o)
    );

    // Read data: bring the addressed bytes down to bit 0, then clear above the size
    always_comb begin
        rdata_shifted = m_axil_rdata_i >> {offset, 3'b000};
        case (header_reg.size)
            e_bedrock_msg_size_1: rdata_masked = rdata_shifted & axil_data_width_p'(8'hFF);
            e_bedrock_msg_size_2: rdata_masked = rdata_shifted & axil_data_width_p'(16'hFFFF);
            e_bedrock_msg_size_4: rdata_masked = rdata_shifted & axil_data_width_p'(32'hFFFF_FFFF);
            default:              rdata_masked = rdata_shifted;
        endcase
    end

    // Bridge FSM with registered handshake outputs and sticky error flag
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg     <= e_ready;
            cmd_ready_reg <= 1'b0;
            aw_pend_reg   <= 1'b0;
            w_pend_reg    <= 1'b0;
            ar_reg        <= 1'b0;
            bready_reg    <= 1'b0;
            rready_reg    <= 1'b0;
            resp_v_reg    <= 1'b0;
            error_reg     <= 1'b0;
            resp_data_reg <= '0;
        end else begin
            case (state_reg)
                e_ready: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready_reg <= 1'b0;
                        resp_data_reg <= '0;
                        if (!cmd_supported) begin
                            resp_v_reg <= 1'b1;
                            error_reg  <= 1'b1;
                            state_reg  <= e_resp;
                        end else if (cmd_is_write) begin
                            aw_pend_reg <= 1'b1;
                            w_pend_reg  <= 1'b1;
                            state_reg   <= e_write;
                        end else begin
                            ar_reg    <= 1'b1;
                            state_reg <= e_read;
                        end
                    end
                end
                e_write: begin
                    if (aw_pend_reg & m_axil_awready_i) aw_pend_reg <= 1'b0;
                    if (w_pend_reg & m_axil_wready_i)   w_pend_reg  <= 1'b0;
                    if ((!aw_pend_reg | m_axil_awready_i) & (!w_pend_reg | m_axil_wready_i)) begin
                        bready_reg <= 1'b1;
                        state_reg  <= e_wait_b;
                    end
                end
                e_wait_b: begin
                    if (m_axil_bvalid_i) begin
                        bready_reg <= 1'b0;
                        resp_v_reg <= 1'b1;
                        state_reg  <= e_resp;
                        if (axi_resp_type_e'(m_axil_bresp_i) != e_axi_resp_okay) error_reg <= 1'b1;
                    end
                end
                e_read: begin
                    if (m_axil_arready_i) begin
                        ar_reg     <= 1'b0;
                        rready_reg <= 1'b1;
                        state_reg  <= e_wait_r;
                    end
                end
                e_wait_r: begin
                    if (m_axil_rvalid_i) begin
                        rready_reg    <= 1'b0;
                        resp_data_reg <= rdata_masked;
                        resp_v_reg    <= 1'b1;
                        state_reg     <= e_resp;
                        if (axi_resp_type_e'(m_axil_rresp_i) != e_axi_resp_okay) error_reg <= 1'b1;
                    end
                end
                e_resp: begin
                    if (io_resp_ready_and_i) begin
                        resp_v_reg    <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= e_ready;
                    end
                end
                default: state_reg <= e_ready;
            endcase
        end
    end

    assign io_cmd_ready_and_o = cmd_ready_reg;
    assign io_resp_header_o   = header_reg;
    assign io_resp_data_o     = resp_data_reg;
    assign io_resp_v_o        = resp_v_reg;
    assign io_resp_last_o     = resp_v_reg;

    assign m_axil_awaddr_o    = axil_addr;
    assign m_axil_awprot_o    = e_axi_prot_default;
    assign m_axil_awvalid_o   = aw_pend_reg;
    assign m_axil_wvalid_o    = w_pend_reg;
    assign m_axil_bready_o    = bready_reg;
    assign m_axil_araddr_o    = axil_addr;
    assign m_axil_arprot_o    = e_axi_prot_default;
    assign m_axil_arvalid_o   = ar_reg;
    assign m_axil_rready_o    = rready_reg;
    assign error_o            = error_reg;

endmodule
